// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: receive-only PS/2 device-to-host deserializer.
// Synchronizes and deglitches the PS/2 clock, samples data on each filtered
// falling edge, checks start/odd-parity/stop, and emits a one-cycle FIFO
// write, frame_err or overflow pulse per completed (or timed-out) frame.
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       fifo_full,
  output logic [7:0] data_out,
  output logic       write,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_TERM   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_PRE    = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  logic [FW-1:0] filt_cnt;
  logic          filt_q;
  logic          fall;

  state_t        state_q, state_n;
  logic [2:0]    bitcnt_q, bitcnt_n;
  logic [7:0]    shift_q, shift_n;
  logic          par_q, par_n;
  logic [TW-1:0] to_cnt_q, to_cnt_n;
  logic [7:0]    dout_q, dout_n;
  logic          write_q, write_n;
  logic          ferr_q, ferr_n;
  logic          ovf_q, ovf_n;
  logic          timeout;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign data_out  = dout_q;
  assign write     = write_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

  // Pin synchronizers, preset to the idle-high level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Clock deglitch filter; fall is a registered one-cycle pulse on a 1->0 flip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s != filt_q) begin
        if (filt_cnt == FILT_LAST) begin
          filt_q   <= clk_s;
          filt_cnt <= '0;
          fall     <= filt_q;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Frame FSM next-state, timeout counter and registered outcome pulses.
  always_comb begin
    state_n  = state_q;
    bitcnt_n = bitcnt_q;
    shift_n  = shift_q;
    par_n    = par_q;
    dout_n   = dout_q;
    write_n  = 1'b0;
    ferr_n   = 1'b0;
    ovf_n    = 1'b0;

    if (state_q == IDLE || fall) begin
      to_cnt_n = '0;
    end else if (to_cnt_q != TO_TERM) begin
      to_cnt_n = to_cnt_q + TW'(1);
    end else begin
      to_cnt_n = to_cnt_q;
    end

    // Asserted on the edge at which the counter lands on its terminal count;
    // a simultaneous fall takes priority.
    timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_PRE);

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_n  = DATA;
            bitcnt_n = '0;
          end
        end
        DATA: begin
          shift_n  = {data_s, shift_q[7:1]};
          bitcnt_n = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = data_s;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (data_s && (^{shift_q, par_q})) begin
            if (fifo_full) begin
              ovf_n = 1'b1;
            end else begin
              write_n = 1'b1;
              dout_n  = shift_q;
            end
          end else begin
            ferr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      to_cnt_q <= '0;
      dout_q   <= 8'h00;
      write_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      bitcnt_q <= bitcnt_n;
      shift_q  <= shift_n;
      par_q    <= par_n;
      to_cnt_q <= to_cnt_n;
      dout_q   <= dout_n;
      write_q  <= write_n;
      ferr_q   <= ferr_n;
      ovf_q    <= ovf_n;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed frames plus randomized frames,
// expectations queued by the stimulus and consumed by a separate monitor.
module tb_ps2_rx_frame;

  localparam int S    = 2;
  localparam int F    = 8;
  localparam int T    = 300;
  localparam int HALF = 20;
  localparam int K_WR = 0;
  localparam int K_FE = 1;
  localparam int K_OV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] data_out;
  logic       write;
  logic       frame_err;
  logic       overflow;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall = 0;
  bit   done = 1'b0;

  ps2_rx_frame #(
    .SYNC_STAGES(S),
    .FILTER_LEN(F),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .fifo_full(fifo_full),
    .data_out(data_out),
    .write(write),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  // Reference outcome of one complete frame from the protocol rules.
  task automatic expect_frame(input logic [7:0] b, input logic p, input logic s);
    exp_t e;
    e.data = b;
    e.lat  = S + F + 1;
    if (!(s == 1'b1 && ($countones({b, p}) % 2 == 1))) e.kind = K_FE;
    else if (fifo_full) e.kind = K_OV;
    else e.kind = K_WR;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    last_fall = cyc;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic p, input logic s, input int nbits);
    logic [10:0] bits;
    bits = {s, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    idle(HALF);
  endtask

  // Stimulus.
  initial begin
    exp_t       e;
    logic [7:0] b;
    logic       p;
    logic       s;
    #2 rst = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(10);

    fifo_full = 1'b0;
    expect_frame(8'h1C, 1'b0, 1'b1);
    send(8'h1C, 1'b0, 1'b1, 11);

    expect_frame(8'h1C, 1'b1, 1'b1);
    send(8'h1C, 1'b1, 1'b1, 11);

    fifo_full = 1'b1;
    expect_frame(8'hF0, 1'b1, 1'b1);
    send(8'hF0, 1'b1, 1'b1, 11);
    fifo_full = 1'b0;
    expect_frame(8'hF0, 1'b1, 1'b1);
    send(8'hF0, 1'b1, 1'b1, 11);

    e.kind = K_FE;
    e.data = 8'h00;
    e.lat  = S + F + T;
    sb.push_back(e);
    send(8'hA5, 1'b0, 1'b1, 6);
    idle(T + 20);
    expect_frame(8'h5A, 1'b1, 1'b1);
    send(8'h5A, 1'b1, 1'b1, 11);

    repeat (3) begin
      ps2_clk = 1'b0;
      idle(F - 1);
      ps2_clk = 1'b1;
      idle(15);
    end
    expect_frame(8'h33, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0, 11);

    send(8'h12, 1'b1, 1'b1, 5);
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(10);
    expect_frame(8'h12, 1'b1, 1'b1);
    send(8'h12, 1'b1, 1'b1, 11);

    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      p = (~^b) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      expect_frame(b, p, s);
      send(b, p, s, 11);
      idle($urandom_range(0, 30));
    end
    fifo_full = 1'b0;
    done = 1'b1;
  end

  // Monitor: pops expectations whenever the DUT presents an outcome pulse.
  exp_t       m;
  int         npulse;
  int         kact;
  int         drain = 0;
  logic [7:0] model_dout = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      model_dout = 8'h00;
      checks++;
      if (write || frame_err || overflow || data_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs: got w=%0b fe=%0b ov=%0b d=%h required 0 0 0 00",
                 write, frame_err, overflow, data_out);
      end
    end else begin
      npulse = int'(write) + int'(frame_err) + int'(overflow);
      if (npulse > 0) begin
        checks++;
        if (npulse > 1) begin
          errors++;
          $display("FAIL onehot: got %0d pulses required 1", npulse);
        end
        kact = write ? K_WR : (frame_err ? K_FE : K_OV);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d required none at cycle %0d", kact, cyc);
        end else begin
          m = sb.pop_front();
          checks++;
          if (kact != m.kind) begin
            errors++;
            $display("FAIL kind: got %0d required %0d (byte %h)", kact, m.kind, m.data);
          end
          checks++;
          if (cyc - last_fall != m.lat) begin
            errors++;
            $display("FAIL latency: got %0d required %0d", cyc - last_fall, m.lat);
          end
          if (m.kind == K_WR) model_dout = m.data;
        end
      end
      checks++;
      if (data_out !== model_dout) begin
        errors++;
        $display("FAIL data_out: got %h required %h at cycle %0d", data_out, model_dout, cyc);
      end
      if (done) begin
        drain++;
        if (drain == 200) begin
          checks++;
          if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding required 0", sb.size());
          end
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end
      end
    end
  end

endmodule
